// File: rtl/ativiade5_timer_pkg.sv
// Shared constants for the interval-timer sequencer: timer register map,
// control bit positions and the sequencer state encoding.
package ativiade5_timer_pkg;

    localparam logic [2:0] TMR_STATUS  = 3'd0;
    localparam logic [2:0] TMR_CONTROL = 3'd1;
    localparam logic [2:0] TMR_PERIODL = 3'd2;
    localparam logic [2:0] TMR_PERIODH = 3'd3;

    localparam int ITO   = 0;
    localparam int CONT  = 1;
    localparam int START = 2;
    localparam int STOP  = 3;

    localparam logic [15:0] CTRL_RUN_WORD  = 16'((1 << ITO) | (1 << CONT) | (1 << START));
    localparam logic [15:0] CTRL_STOP_WORD = 16'(1 << STOP);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_WR_PL   = 4'd1,
        ST_WR_PH   = 4'd2,
        ST_WR_CTRL = 4'd3,
        ST_RUN     = 4'd4,
        ST_CLR     = 4'd5,
        ST_RD_ST   = 4'd6,
        ST_CHK     = 4'd7,
        ST_STOP    = 4'd8
    } state_e;

endpackage

// File: rtl/ativiade5_timer_sequencer.sv
// Avalon-MM master that programs the interval timer, then services each timer
// IRQ by clearing TO, confirming the clear by read-back and counting the tick.
module ativiade5_timer_sequencer
    import ativiade5_timer_pkg::*;
#(
    parameter logic [31:0] PERIOD = 32'd50000,
    parameter int          TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              timer_irq,
    output logic [2:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [15:0]       avm_writedata,
    input  logic [15:0]       avm_readdata,
    output logic [TICK_W-1:0] tick_count,
    output logic              tick_pulse,
    output logic              busy,
    output logic              clr_err,
    output logic [3:0]        dbg_state
);

    localparam logic [3:0] S_IDLE    = ST_IDLE;
    localparam logic [3:0] S_WR_PL   = ST_WR_PL;
    localparam logic [3:0] S_WR_PH   = ST_WR_PH;
    localparam logic [3:0] S_WR_CTRL = ST_WR_CTRL;
    localparam logic [3:0] S_RUN     = ST_RUN;
    localparam logic [3:0] S_CLR     = ST_CLR;
    localparam logic [3:0] S_RD_ST   = ST_RD_ST;
    localparam logic [3:0] S_CHK     = ST_CHK;
    localparam logic [3:0] S_STOP    = ST_STOP;

    // The timer counts from the programmed value down to zero inclusive.
    localparam logic [31:0] PERIOD_M1 = PERIOD - 32'd1;
    localparam logic [TICK_W-1:0] TICK_ONE = {{(TICK_W-1){1'b0}}, 1'b1};

    logic [3:0]        state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              pulse_q, pulse_d;
    logic              err_q, err_d;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        pulse_d = 1'b0;
        err_d   = err_q;
        case (state_q)
            S_IDLE:    if (enable) state_d = S_WR_PL;
            S_WR_PL:   state_d = S_WR_PH;
            S_WR_PH:   state_d = S_WR_CTRL;
            S_WR_CTRL: state_d = S_RUN;
            // A pending IRQ is always serviced before a stop request.
            S_RUN: begin
                if (timer_irq)    state_d = S_CLR;
                else if (!enable) state_d = S_STOP;
            end
            S_CLR:   state_d = S_RD_ST;
            S_RD_ST: state_d = S_CHK;
            S_CHK: begin
                if (avm_readdata[0]) begin
                    err_d   = 1'b1;
                    state_d = S_CLR;
                end else begin
                    tick_d  = tick_q + TICK_ONE;
                    pulse_d = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_STOP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            pulse_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            pulse_q <= pulse_d;
            err_q   <= err_d;
        end
    end

    // Bus outputs depend on the registered state only.
    always_comb begin
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_address    = TMR_STATUS;
        avm_writedata  = 16'h0000;
        case (state_q)
            S_WR_PL: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = TMR_PERIODL;
                avm_writedata  = PERIOD_M1[15:0];
            end
            S_WR_PH: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = TMR_PERIODH;
                avm_writedata  = PERIOD_M1[31:16];
            end
            S_WR_CTRL: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = TMR_CONTROL;
                avm_writedata  = CTRL_RUN_WORD;
            end
            S_CLR: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = TMR_STATUS;
            end
            S_RD_ST: begin
                avm_chipselect = 1'b1;
                avm_address    = TMR_STATUS;
            end
            S_STOP: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = TMR_CONTROL;
                avm_writedata  = CTRL_STOP_WORD;
            end
            default: ;
        endcase
    end

    assign tick_count = tick_q;
    assign tick_pulse = pulse_q;
    assign clr_err    = err_q;
    assign busy       = (state_q != S_IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ativiade5_timer_sequencer.sv
// Bench for the timer sequencer: behavioural interval timer, bus and tick
// scoreboards fed from the timer model and the stimulus, and a final report.
module tb_ativiade5_timer_sequencer;
    import ativiade5_timer_pkg::*;

    localparam int TW = 4;
    localparam logic [31:0] PER = 32'd10;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          enable;
    logic          timer_irq;
    logic [2:0]    avm_address;
    logic          avm_chipselect;
    logic          avm_write_n;
    logic [15:0]   avm_writedata;
    logic [15:0]   avm_readdata;
    logic [TW-1:0] tick_count;
    logic          tick_pulse;
    logic          busy;
    logic          clr_err;
    logic [3:0]    dbg_state;

    ativiade5_timer_sequencer #(.PERIOD(PER), .TICK_W(TW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .timer_irq(timer_irq),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata), .tick_count(tick_count),
        .tick_pulse(tick_pulse), .busy(busy), .clr_err(clr_err),
        .dbg_state(dbg_state)
    );

    int errors = 0;
    int checks = 0;
    logic [19:0]   exp_q[$];
    logic [TW-1:0] tick_exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [19:0] wr_word(input logic [2:0] a, input logic [15:0] d);
        return {1'b0, a, d};
    endfunction

    localparam logic [19:0] RD_STATUS = {1'b1, 3'd0, 16'h0000};

    // behavioural interval timer
    logic [15:0]   t_pl, t_ph;
    logic          t_ito, t_cont, t_run, t_to;
    logic [31:0]   t_cnt;
    logic [TW-1:0] t_exp_tick;
    int            rd_count;
    int            force_at = -1;
    logic [31:0]   t_period;
    assign t_period  = {t_ph, t_pl};
    assign timer_irq = t_to & t_ito;

    always @(posedge clk) begin
        if (reset) begin
            t_pl <= '0; t_ph <= '0; t_ito <= 1'b0; t_cont <= 1'b0;
            t_run <= 1'b0; t_to <= 1'b0; t_cnt <= '0; t_exp_tick <= '0;
            rd_count <= 0; avm_readdata <= '0;
        end else begin
            if (t_run) begin
                if (t_cnt == 0) begin
                    t_to  <= 1'b1;
                    t_cnt <= t_period;
                    if (!t_cont) t_run <= 1'b0;
                    exp_q.push_back(wr_word(TMR_STATUS, 16'h0000));
                    exp_q.push_back(RD_STATUS);
                    tick_exp_q.push_back(t_exp_tick + 1'b1);
                    t_exp_tick <= t_exp_tick + 1'b1;
                end else begin
                    t_cnt <= t_cnt - 1;
                end
            end
            if (avm_chipselect && !avm_write_n) begin
                case (avm_address)
                    3'd0: t_to <= 1'b0;
                    3'd1: begin
                        t_ito  <= avm_writedata[0];
                        t_cont <= avm_writedata[1];
                        if (avm_writedata[2]) begin t_run <= 1'b1; t_cnt <= t_period; end
                        if (avm_writedata[3]) t_run <= 1'b0;
                    end
                    3'd2: begin t_pl <= avm_writedata; t_run <= 1'b0; end
                    3'd3: begin t_ph <= avm_writedata; t_run <= 1'b0; end
                    default: ;
                endcase
            end
            case (avm_address)
                3'd0: begin
                    if (avm_chipselect && avm_write_n) begin
                        rd_count <= rd_count + 1;
                        if (rd_count == force_at) begin
                            avm_readdata <= {14'd0, t_run, 1'b1};
                            exp_q.push_back(wr_word(TMR_STATUS, 16'h0000));
                            exp_q.push_back(RD_STATUS);
                        end else begin
                            avm_readdata <= {14'd0, t_run, t_to};
                        end
                    end else begin
                        avm_readdata <= {14'd0, t_run, t_to};
                    end
                end
                3'd1:    avm_readdata <= {13'd0, t_run, t_cont, t_ito};
                3'd2:    avm_readdata <= t_pl;
                3'd3:    avm_readdata <= t_ph;
                default: avm_readdata <= '0;
            endcase
        end
    end

    // scoreboard monitor
    int   cyc = 0;
    int   pulse_cnt = 0;
    int   last_pulse = 0;
    logic have_last = 1'b0;
    logic chk_interval = 1'b0;
    logic wrap_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (avm_chipselect) begin
                check_eq("bus_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0)
                    check_eq("bus_access", 32'({avm_write_n, avm_address, avm_writedata}), 32'(exp_q.pop_front()));
            end else begin
                check_eq("bus_idle", 32'({avm_write_n, avm_address, avm_writedata}), 32'({1'b1, 3'd0, 16'd0}));
            end
            if (tick_pulse) begin
                pulse_cnt++;
                if (tick_count == 0) wrap_seen = 1'b1;
                check_eq("tick_q_nonempty", 32'(tick_exp_q.size() != 0), 32'd1);
                if (tick_exp_q.size() != 0)
                    check_eq("tick_count", 32'(tick_count), 32'(tick_exp_q.pop_front()));
                if (have_last && chk_interval)
                    check_eq("tick_interval", 32'(cyc - last_pulse), 32'd10);
                last_pulse = cyc;
                have_last  = 1'b1;
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_enable();
        enable = 1'b1;
        exp_q.push_back(wr_word(TMR_PERIODL, 16'h0009));
        exp_q.push_back(wr_word(TMR_PERIODH, 16'h0000));
        exp_q.push_back(wr_word(TMR_CONTROL, 16'h0007));
        step();
        check_eq("busy_first_write", 32'(busy), 32'd1);
        check_eq("state_wr_pl", 32'(dbg_state), 32'(ST_WR_PL));
    endtask

    task automatic wait_pulses(input int target, input int budget);
        int n = 0;
        while (pulse_cnt < target && n < budget) begin
            step();
            n++;
        end
        check_eq("wait_pulses_done", 32'(pulse_cnt >= target), 32'd1);
    endtask

    task automatic wait_state(input logic [3:0] st, input int budget);
        int n = 0;
        while (dbg_state != st && n < budget) begin
            step();
            n++;
        end
        check_eq("wait_state_done", 32'(dbg_state), 32'(st));
    endtask

    initial begin
        int n;
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_tick", 32'(tick_count), 32'd0);
        check_eq("rst_pulse", 32'(tick_pulse), 32'd0);
        check_eq("rst_clr_err", 32'(clr_err), 32'd0);
        check_eq("rst_cs", 32'(avm_chipselect), 32'd0);
        reset = 1'b0;
        step();

        // configuration and steady run
        chk_interval = 1'b1;
        start_enable();
        wait_pulses(5, 200);
        check_eq("tick_after_5", 32'(tick_count), 32'd5);
        check_eq("clr_err_clean", 32'(clr_err), 32'd0);

        // status read-back still shows TO once
        chk_interval = 1'b0;
        force_at = rd_count;
        wait_pulses(6, 100);
        check_eq("clr_err_set", 32'(clr_err), 32'd1);
        check_eq("tick_after_retry", 32'(tick_count), 32'd6);

        // reset in the middle of a service
        wait_state(ST_RD_ST, 40);
        reset  = 1'b1;
        enable = 1'b0;
        step();
        check_eq("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("midrst_tick", 32'(tick_count), 32'd0);
        check_eq("midrst_cs", 32'(avm_chipselect), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_clr_err", 32'(clr_err), 32'd0);
        exp_q.delete();
        tick_exp_q.delete();
        reset = 1'b0;
        step();
        start_enable();
        wait_pulses(pulse_cnt + 17, 400);
        check_eq("wrap_seen", 32'(wrap_seen), 32'd1);
        check_eq("tick_after_17", 32'(tick_count), 32'd1);

        // IRQ and enable fall in the same RUN cycle
        n = 0;
        while (!timer_irq && n < 40) begin
            step();
            n++;
        end
        check_eq("irq_seen", 32'(timer_irq), 32'd1);
        check_eq("irq_in_run", 32'(dbg_state), 32'(ST_RUN));
        enable = 1'b0;
        exp_q.push_back(wr_word(TMR_CONTROL, 16'h0008));
        step();
        check_eq("stop_clr_first", 32'(dbg_state), 32'(ST_CLR));
        wait_state(ST_STOP, 20);
        check_eq("stop_tick", 32'(tick_count), 32'd2);
        step();
        check_eq("stop_idle", 32'(dbg_state), 32'(ST_IDLE));
        step();
        check_eq("timer_run_bit", 32'(t_run), 32'd0);
        check_eq("stop_busy", 32'(busy), 32'd0);
        repeat (15) step();
        check_eq("bus_q_drained", 32'(exp_q.size()), 32'd0);
        check_eq("tick_q_drained", 32'(tick_exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
